// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the MEM->WB pipeline stage.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_W  = 5;

  // One MEM->WB entry, moved between slots as a single vector.
  typedef struct packed {
    logic                   regwrite;
    logic                   memtoreg;
    logic [PIPE_DATA_W-1:0] aluout;
    logic [PIPE_DATA_W-1:0] readdata;
    logic [PIPE_REG_W-1:0]  writereg;
    logic [PIPE_DATA_W-1:0] instr;
  } mem_wb_payload_t;

  // Flattened payload width for arbitrary data / register-index widths.
  function automatic int payload_w(input int data_w, input int reg_w);
    return 2 + 3 * data_w + reg_w;
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline storage slot: payload register plus valid bit.
// Priority: reset > clear > load > unload. Payload only changes on load.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: load wins over unload so a simultaneous refill keeps the slot full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB stage register with valid/ready handshake, flush, optional skid
// slot for full throughput under back-pressure, and a retired-entry counter.
module mem_wb_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_W  = PIPE_REG_W,
  parameter int CNT_W  = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_aluout,
  input  logic [DATA_W-1:0] in_readdata,
  input  logic [REG_W-1:0]  in_writereg,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic              out_memtoreg,
  output logic [DATA_W-1:0] out_aluout,
  output logic [DATA_W-1:0] out_readdata,
  output logic [REG_W-1:0]  out_writereg,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_wbdata,
  output logic              retire_strobe,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int PAY_W = payload_w(DATA_W, REG_W);

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay;
  logic [PAY_W-1:0] main_load_data;
  logic             main_valid;
  logic             main_load;
  logic             accept;
  logic             rel;
  logic             main_regwrite;

  assign in_pay = {in_regwrite, in_memtoreg, in_aluout, in_readdata, in_writereg, in_instr};

  assign accept = in_valid && in_ready;
  assign rel    = main_valid && out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_valid;
      logic [PAY_W-1:0] skid_pay;
      logic             skid_load;

      // Registered ready: only a full skid slot blocks upstream.
      assign in_ready = !skid_valid;

      // Main refills from skid first (FIFO order), otherwise from the input
      // when it is empty or being drained this cycle.
      assign main_load      = (accept && (!main_valid || rel)) || (rel && skid_valid);
      assign main_load_data = skid_valid ? skid_pay : in_pay;

      // Input lands in skid only while main is held by back-pressure.
      assign skid_load = accept && main_valid && !out_ready;

      pipe_skid_slot #(.W(PAY_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (flush),
        .load_i   (skid_load),
        .unload_i (rel),
        .data_i   (in_pay),
        .valid_o  (skid_valid),
        .data_o   (skid_pay)
      );
    end else begin : g_noskid
      // Single entry: accept when empty or draining in the same cycle.
      assign in_ready       = !main_valid || out_ready;
      assign main_load      = accept;
      assign main_load_data = in_pay;
    end
  endgenerate

  pipe_skid_slot #(.W(PAY_W)) u_main (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (flush),
    .load_i   (main_load),
    .unload_i (rel),
    .data_i   (main_load_data),
    .valid_o  (main_valid),
    .data_o   (main_pay)
  );

  assign {main_regwrite, out_memtoreg, out_aluout, out_readdata, out_writereg, out_instr} = main_pay;

  assign out_valid     = main_valid;
  // A bubble must never write the register file.
  assign out_regwrite  = main_regwrite && main_valid;
  assign out_wbdata    = out_memtoreg ? out_readdata : out_aluout;
  assign retire_strobe = main_valid && out_ready;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count releases; a release coinciding with flush is discarded, not retired.
  always_comb begin
    cnt_d = cnt_q;
    if (retire_strobe && !flush) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Retired-entry counter register; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Self-checking bench: SKID=1 and SKID=0 instances share stimulus; a queue
// model per instance predicts every output, plus table and hand sequences.
module tb_mem_wb_stage_reg;
  import pipe_pkg::*;

  localparam int CW    = 4;
  localparam int CMASK = (1 << CW) - 1;

  typedef mem_wb_payload_t pay_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic        in_regwrite, in_memtoreg;
  logic [31:0] in_aluout, in_readdata, in_instr;
  logic [4:0]  in_writereg;

  logic          in_ready1, out_valid1, out_regwrite1, out_memtoreg1, retire_strobe1;
  logic [31:0]   out_aluout1, out_readdata1, out_instr1, out_wbdata1;
  logic [4:0]    out_writereg1;
  logic [CW-1:0] retire_count1;

  logic          in_ready0, out_valid0, out_regwrite0, out_memtoreg0, retire_strobe0;
  logic [31:0]   out_aluout0, out_readdata0, out_instr0, out_wbdata0;
  logic [4:0]    out_writereg0;
  logic [CW-1:0] retire_count0;

  mem_wb_stage_reg #(.DATA_W(32), .REG_W(5), .CNT_W(CW), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_aluout(in_aluout),
    .in_readdata(in_readdata), .in_writereg(in_writereg), .in_instr(in_instr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_regwrite(out_regwrite1),
    .out_memtoreg(out_memtoreg1), .out_aluout(out_aluout1), .out_readdata(out_readdata1),
    .out_writereg(out_writereg1), .out_instr(out_instr1), .out_wbdata(out_wbdata1),
    .retire_strobe(retire_strobe1), .retire_count(retire_count1)
  );

  mem_wb_stage_reg #(.DATA_W(32), .REG_W(5), .CNT_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_aluout(in_aluout),
    .in_readdata(in_readdata), .in_writereg(in_writereg), .in_instr(in_instr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_regwrite(out_regwrite0),
    .out_memtoreg(out_memtoreg0), .out_aluout(out_aluout0), .out_readdata(out_readdata0),
    .out_writereg(out_writereg0), .out_instr(out_instr0), .out_wbdata(out_wbdata0),
    .retire_strobe(retire_strobe0), .retire_count(retire_count0)
  );

  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;
  bit   acc1_last, acc0_last;
  pay_t q1[$];
  pay_t q0[$];
  int   cnt1 = 0;
  int   cnt0 = 0;

  typedef struct {
    bit          v;
    logic [31:0] alu;
    bit          ordy;
    bit          e_ov;
    bit          e_ir;
    logic [31:0] e_alu;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] alu, input logic mtr, input logic [31:0] rd);
    pay_t p;
    p.regwrite = 1'b1;
    p.memtoreg = mtr;
    p.aluout   = alu;
    p.readdata = rd;
    p.writereg = alu[4:0];
    p.instr    = {alu[15:0], 16'h0013};
    return p;
  endfunction

  task automatic drive(input bit v, input pay_t p);
    in_valid    = v;
    in_regwrite = p.regwrite;
    in_memtoreg = p.memtoreg;
    in_aluout   = p.aluout;
    in_readdata = p.readdata;
    in_writereg = p.writereg;
    in_instr    = p.instr;
  endtask

  task automatic check_side(input string tag, input pay_t ep, input bit ev, input bit eir,
                            input bit ers, input int ecnt,
                            input logic ov, input logic ir, input logic rs, input logic [CW-1:0] rc,
                            input logic rw, input logic mtr, input logic [31:0] alu,
                            input logic [31:0] rd, input logic [4:0] wr, input logic [31:0] ins,
                            input logic [31:0] wb);
    chk({tag, "_out_valid"},     64'(ov), 64'(ev));
    chk({tag, "_in_ready"},      64'(ir), 64'(eir));
    chk({tag, "_retire_strobe"}, 64'(rs), 64'(ers));
    chk({tag, "_retire_count"},  64'(rc), 64'(ecnt));
    chk({tag, "_out_regwrite"},  64'(rw), 64'(ev & ep.regwrite));
    if (ev) begin
      chk({tag, "_memtoreg"}, 64'(mtr), 64'(ep.memtoreg));
      chk({tag, "_aluout"},   64'(alu), 64'(ep.aluout));
      chk({tag, "_readdata"}, 64'(rd),  64'(ep.readdata));
      chk({tag, "_writereg"}, 64'(wr),  64'(ep.writereg));
      chk({tag, "_instr"},    64'(ins), 64'(ep.instr));
      chk({tag, "_wbdata"},   64'(wb),  64'(ep.memtoreg ? ep.readdata : ep.aluout));
    end
  endtask

  // One clock: check both DUTs against the model at negedge, advance model, cross posedge.
  task automatic step();
    bit   v1, v0, r1, r0;
    pay_t f1, f0, cur, tmp;
    @(negedge clk);
    v1  = (q1.size() != 0);
    v0  = (q0.size() != 0);
    f1  = v1 ? q1[0] : '0;
    f0  = v0 ? q0[0] : '0;
    r1  = (q1.size() < 2);
    r0  = !v0 || out_ready;
    cur = {in_regwrite, in_memtoreg, in_aluout, in_readdata, in_writereg, in_instr};
    if (chk_en) begin
      check_side("s1", f1, v1, r1, v1 && out_ready, cnt1, out_valid1, in_ready1, retire_strobe1,
                 retire_count1, out_regwrite1, out_memtoreg1, out_aluout1, out_readdata1,
                 out_writereg1, out_instr1, out_wbdata1);
      check_side("s0", f0, v0, r0, v0 && out_ready, cnt0, out_valid0, in_ready0, retire_strobe0,
                 retire_count0, out_regwrite0, out_memtoreg0, out_aluout0, out_readdata0,
                 out_writereg0, out_instr0, out_wbdata0);
    end
    acc1_last = 1'b0;
    acc0_last = 1'b0;
    if (!rst_n || flush) begin
      q1.delete();
      q0.delete();
      if (!rst_n) begin
        cnt1 = 0;
        cnt0 = 0;
      end
    end else begin
      if (v1 && out_ready) begin
        tmp  = q1.pop_front();
        cnt1 = (cnt1 + 1) & CMASK;
        $display("s1 retire alu=0x%08h count=%0d", tmp.aluout, cnt1);
      end
      if (v0 && out_ready) begin
        tmp  = q0.pop_front();
        cnt0 = (cnt0 + 1) & CMASK;
        $display("s0 retire alu=0x%08h count=%0d", tmp.aluout, cnt0);
      end
      if (in_valid && r1) begin
        q1.push_back(cur);
        acc1_last = 1'b1;
      end
      if (in_valid && r0) begin
        q0.push_back(cur);
        acc0_last = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) chk_en = 1'b1;
  endtask

  initial begin
    int saved;
    int idx;

    // SKID=1 back-pressure: A held, B in skid, C waits upstream, then drain.
    vt[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[1] = '{1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h100};
    vt[2] = '{1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h100};
    vt[3] = '{1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 32'h100};
    vt[4] = '{1'b1, 32'h300, 1'b1, 1'b1, 1'b0, 32'h100};
    vt[5] = '{1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 32'h200};
    vt[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h300};
    vt[7] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0};

    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, mk(32'h55, 1'b0, 32'h0));

    // Reset held two cycles with an offered input.
    step();
    step();
    rst_n = 1'b1;
    drive(1'b0, mk(32'h0, 1'b0, 32'h0));
    #1;
    chk("rst_in_ready",     64'(in_ready1),     64'(1));
    chk("rst_out_valid",    64'(out_valid1),    64'(0));
    chk("rst_out_regwrite", 64'(out_regwrite1), 64'(0));
    chk("rst_retire_count", 64'(retire_count1), 64'(0));

    // Streaming at full rate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(32'h10 + 32'(i), 1'b0, 32'h0));
      step();
    end
    drive(1'b0, mk(32'h0, 1'b0, 32'h0));
    step();
    step();
    chk("stream_count", 64'(retire_count1), 64'(4));

    // Back-pressure table.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].v, mk(vt[i].alu, 1'b0, 32'h0));
      out_ready = vt[i].ordy;
      #1;
      chk("bp_out_valid", 64'(out_valid1), 64'(vt[i].e_ov));
      chk("bp_in_ready",  64'(in_ready1),  64'(vt[i].e_ir));
      if (vt[i].e_ov) chk("bp_aluout", 64'(out_aluout1), 64'(vt[i].e_alu));
      step();
    end
    step();
    step();

    // SKID=0 back-pressure: upstream follows the single-entry instance's handshake.
    idx = 0;
    for (int c = 0; c < 30 && (idx < 3 || q0.size() != 0); c++) begin
      drive(idx < 3, mk(32'h400 + 32'(idx) * 32'h100, 1'b0, 32'h0));
      out_ready = (c >= 3);
      #1;
      if (c == 1 || c == 2) chk("s0_stall_in_ready", 64'(in_ready0), 64'(0));
      step();
      if (acc0_last) idx++;
    end
    chk("s0_all_sent", 64'(idx), 64'(3));
    drive(1'b0, mk(32'h0, 1'b0, 32'h0));
    out_ready = 1'b1;
    step();
    step();
    step();

    // Flush with main and skid full and an input offered.
    out_ready = 1'b0;
    drive(1'b1, mk(32'h700, 1'b0, 32'h0));
    step();
    drive(1'b1, mk(32'h800, 1'b0, 32'h0));
    step();
    chk("fl_full_in_ready", 64'(in_ready1), 64'(0));
    saved = cnt1;
    flush = 1'b1;
    drive(1'b1, mk(32'h900, 1'b0, 32'h0));
    step();
    flush = 1'b0;
    drive(1'b0, mk(32'h0, 1'b0, 32'h0));
    #1;
    chk("fl_out_valid", 64'(out_valid1),    64'(0));
    chk("fl_in_ready",  64'(in_ready1),     64'(1));
    chk("fl_count",     64'(retire_count1), 64'(saved));
    out_ready = 1'b1;
    step();
    step();

    // Flush coinciding with a release must not count.
    drive(1'b1, mk(32'hA00, 1'b0, 32'h0));
    step();
    saved = cnt1;
    flush = 1'b1;
    drive(1'b0, mk(32'h0, 1'b0, 32'h0));
    step();
    flush = 1'b0;
    chk("fl_rel_count", 64'(retire_count1), 64'(saved));
    step();

    // Writeback mux, then a bubble carrying regwrite=1.
    drive(1'b1, mk(32'h4, 1'b1, 32'hDEAD_BEEF));
    step();
    drive(1'b0, mk(32'h8, 1'b0, 32'h0));
    #1;
    chk("wb_data", 64'(out_wbdata1), 64'(32'hDEAD_BEEF));
    step();
    chk("bubble_regwrite1", 64'(out_regwrite1), 64'(0));
    chk("bubble_regwrite0", 64'(out_regwrite0), 64'(0));
    step();

    // Counter wrap: 17 retirements on a 4-bit counter.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, mk(32'hB00 + 32'(i), 1'b0, 32'h0));
      step();
    end
    drive(1'b0, mk(32'h0, 1'b0, 32'h0));
    step();
    step();
    chk("wrap_count1", 64'(retire_count1), 64'(1));
    chk("wrap_count0", 64'(retire_count0), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
